red_pitaya_sort_scheduler: RTL and testbench

- Schedules actuator pulses for the droplet sorter.
- The FADS evaluation logic issues a 1-cycle sort request at the detection point. This block timestamps the request and queues it.
- It fires sort_trig a programmable delay later, when the droplet reaches the electrodes.
- It enforces pulse width and guard time between pulses. It drops and counts requests that overflow the queue or can no longer be served on time.

---
 rtl/red_pitaya_sort_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_red_pitaya_sort_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_sort_scheduler.sv
// Droplet-sorter pulse scheduler: timestamps sort requests, queues their actuation
// targets and fires sort_trig_o at the target time with enforced width and guard.
module red_pitaya_sort_scheduler #(
  parameter int QSZ = 3,
  parameter int TW  = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          enable_i,
  input  logic          flush_i,
  input  logic          sort_req_i,
  input  logic [TW-1:0] delay_cfg_i,
  input  logic [TW-1:0] duration_cfg_i,
  input  logic [TW-1:0] guard_cfg_i,
  output logic          sort_trig_o,
  output logic          busy_o,
  output logic [QSZ:0]  q_count_o,
  output logic [TW-1:0] fired_cnt_o,
  output logic [TW-1:0] drop_cnt_o,
  output logic [TW-1:0] late_cnt_o
);

  localparam int DEPTH = 1 << QSZ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FIRE,
    S_GUARD
  } state_t;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + TW'(1);
  endfunction

  function automatic logic [TW-1:0] min_one(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  logic [TW-1:0]  ts_q, ts_d;
  logic [TW-1:0]  mem_q [DEPTH];
  logic [QSZ-1:0] wr_ptr_q, wr_ptr_d;
  logic [QSZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [QSZ:0]   count_q, count_d;
  state_t         state_q, state_d;
  logic           trig_q, trig_d;
  logic [TW-1:0]  fired_q, fired_d;
  logic [TW-1:0]  drop_q, drop_d;
  logic [TW-1:0]  late_q, late_d;
  logic [TW-1:0]  target_q, target_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  guard_q, guard_d;

  logic           push_req;
  logic           full;
  logic           push_ok;
  logic           pop;
  logic [TW-1:0]  push_tgt;
  logic [TW-1:0]  diff;

  assign push_req = sort_req_i & enable_i & ~flush_i;
  assign full     = (count_q == (QSZ+1)'(DEPTH));
  assign push_ok  = push_req & ~full;
  assign push_tgt = ts_q + delay_cfg_i;
  // Modular distance: zero means on time, small positive means the target has passed.
  assign diff     = ts_q - target_q;

  always_comb begin
    ts_d     = ts_q + TW'(1);
    state_d  = state_q;
    trig_d   = trig_q;
    fired_d  = fired_q;
    drop_d   = drop_q;
    late_d   = late_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    guard_d  = guard_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;

    if (push_req && full) begin
      drop_d = sat_inc(drop_q);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          target_d = mem_q[rd_ptr_q];
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (diff == '0) begin
          state_d = S_FIRE;
          trig_d  = 1'b1;
          cnt_d   = min_one(duration_cfg_i);
          guard_d = guard_cfg_i;
          fired_d = sat_inc(fired_q);
        end else if (!diff[TW-1]) begin
          late_d  = sat_inc(late_q);
          state_d = S_IDLE;
        end
      end
      S_FIRE: begin
        if (cnt_q <= TW'(1)) begin
          trig_d = 1'b0;
          if (guard_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GUARD;
            cnt_d   = guard_q;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_GUARD: begin
        if (cnt_q <= TW'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
      end
    endcase

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + QSZ'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + QSZ'(1);
    end
    count_d = count_q + (QSZ+1)'(push_ok) - (QSZ+1)'(pop);

    // Flush overrides any pop, fire or late decision made this cycle.
    if (flush_i) begin
      state_d  = S_IDLE;
      trig_d   = 1'b0;
      fired_d  = fired_q;
      late_d   = late_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      ts_q     <= '0;
      state_q  <= S_IDLE;
      trig_q   <= 1'b0;
      fired_q  <= '0;
      drop_q   <= '0;
      late_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ts_q     <= ts_d;
      state_q  <= state_d;
      trig_q   <= trig_d;
      fired_q  <= fired_d;
      drop_q   <= drop_d;
      late_q   <= late_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath registers are only consumed in states that load them first.
  always_ff @(posedge adc_clk_i) begin
    target_q <= target_d;
    cnt_q    <= cnt_d;
    guard_q  <= guard_d;
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_tgt;
    end
  end

  assign sort_trig_o = trig_q;
  assign busy_o      = (state_q != S_IDLE) | (count_q != '0);
  assign q_count_o   = count_q;
  assign fired_cnt_o = fired_q;
  assign drop_cnt_o  = drop_q;
  assign late_cnt_o  = late_q;

endmodule

// File: tb/tb_red_pitaya_sort_scheduler.sv
// Bench for the sort scheduler: an event-level reference model predicts pulse
// edges, occupancy, busy and counters; a negedge monitor compares every cycle.
module tb_red_pitaya_sort_scheduler;

  localparam int QSZ   = 3;
  localparam int TW    = 32;
  localparam int DEPTH = 8;
  localparam longint BIG = 64'h3FFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic          req;
  logic [TW-1:0] delay;
  logic [TW-1:0] dur;
  logic [TW-1:0] guard;
  logic          sort_trig_o;
  logic          busy_o;
  logic [QSZ:0]  q_count_o;
  logic [TW-1:0] fired_cnt_o;
  logic [TW-1:0] drop_cnt_o;
  logic [TW-1:0] late_cnt_o;

  always #5 clk = ~clk;

  red_pitaya_sort_scheduler #(.QSZ(QSZ), .TW(TW)) dut (
    .adc_clk_i      (clk),
    .adc_rst_i      (rst),
    .enable_i       (en),
    .flush_i        (flush),
    .sort_req_i     (req),
    .delay_cfg_i    (delay),
    .duration_cfg_i (dur),
    .guard_cfg_i    (guard),
    .sort_trig_o    (sort_trig_o),
    .busy_o         (busy_o),
    .q_count_o      (q_count_o),
    .fired_cnt_o    (fired_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .late_cnt_o     (late_cnt_o)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     mon_en   = 1'b0;
  int     mon_rd   = 0;

  // Reference model state, in absolute cycle numbers.
  longint mq[$];
  longint m_free_at   = 0;
  longint m_pend      = -1;
  bit     m_pend_fire = 1'b0;
  longint m_fired = 0, m_late = 0, m_drop = 0;
  longint exp_start[$];
  longint exp_fall[$];
  longint abort_cyc = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_idle();
    return (m_free_at <= cyc) && (mq.size() == 0) && (m_pend < 0);
  endfunction

  task automatic model_step(input longint c);
    int     occ;
    longint tc;
    longint n;
    if (rst || flush) begin
      mq.delete();
      m_free_at = c + 1;
      m_pend    = -1;
      abort_cyc = c + 1;
      if (rst) begin
        m_fired = 0;
        m_late  = 0;
        m_drop  = 0;
      end
      return;
    end
    occ = mq.size();
    if (m_pend == c) begin
      if (m_pend_fire) begin
        n = (dur == 0) ? 1 : longint'(dur);
        m_fired++;
        exp_start.push_back(c + 1);
        exp_fall.push_back(c + 1 + n);
        m_free_at = c + 1 + n + longint'(guard);
      end else begin
        m_late++;
        m_free_at = c + 1;
      end
      m_pend = -1;
    end else if (m_pend < 0 && c >= m_free_at && occ > 0) begin
      tc = mq.pop_front();
      m_free_at = BIG;
      if (tc >= c + 1) begin
        m_pend      = tc;
        m_pend_fire = 1'b1;
      end else begin
        m_pend      = c + 1;
        m_pend_fire = 1'b0;
      end
    end
    if (req && en) begin
      if (occ == DEPTH) m_drop++;
      else mq.push_back(c + longint'(delay));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(cyc);
      cyc++;
    end
  end

  // Monitor: checks pulse edges against the scoreboard and status every cycle.
  initial begin
    bit     prev = 1'b0;
    longint rc   = 0;
    longint ef   = 0;
    longint e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", longint'(busy_o), longint'((cyc < m_free_at) || (mq.size() != 0)));
        chk("q_count", longint'(q_count_o), longint'(mq.size()));
        chk("fired_cnt", longint'(fired_cnt_o), m_fired);
        chk("drop_cnt", longint'(drop_cnt_o), m_drop);
        chk("late_cnt", longint'(late_cnt_o), m_late);
        if (sort_trig_o === 1'b1 && !prev) begin
          rc = cyc;
          if (mon_rd >= exp_start.size()) begin
            chk("unexpected_pulse_start", cyc, -1);
          end else begin
            chk("pulse_start", cyc, exp_start[mon_rd]);
            ef = exp_fall[mon_rd];
            mon_rd++;
          end
        end
        if (sort_trig_o !== 1'b1 && prev) begin
          e = ef;
          if (abort_cyc > rc && abort_cyc < ef) e = abort_cyc;
          chk("pulse_end", cyc, e);
        end
      end
      prev = (sort_trig_o === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request();
    req = 1'b1;
    step(1);
    req = 1'b0;
  endtask

  task automatic cfg(input int d, input int n, input int g);
    delay = TW'(d);
    dur   = TW'(n);
    guard = TW'(g);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy_o || !model_idle()) && k < budget) begin
      step(1);
      k++;
    end
    chk("idle_reached", longint'(busy_o), 0);
    step(2);
  endtask

  task automatic wait_trig(input int budget);
    int k = 0;
    while (sort_trig_o !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk("trig_seen", longint'(sort_trig_o), 1);
  endtask

  initial begin
    longint t;
    int     peak;
    longint f0, l0, d0;
    rst = 1'b1; en = 1'b1; flush = 1'b0; req = 1'b0;
    cfg(100, 10, 5);
    step(3);
    chk("rst_trig", longint'(sort_trig_o), 0);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_qcount", longint'(q_count_o), 0);
    chk("rst_fired", longint'(fired_cnt_o), 0);
    chk("rst_drop", longint'(drop_cnt_o), 0);
    chk("rst_late", longint'(late_cnt_o), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step(3);

    // Single pulse: high t+101..t+110, guard until t+115, idle at t+116.
    t = cyc;
    request();
    step(99);
    chk("t1_pre_pulse", longint'(sort_trig_o), 0);
    step(1);
    chk("t1_pulse_first", longint'(sort_trig_o), 1);
    step(9);
    chk("t1_pulse_last", longint'(sort_trig_o), 1);
    step(1);
    chk("t1_pulse_off", longint'(sort_trig_o), 0);
    step(4);
    chk("t1_busy_guard", longint'(busy_o), 1);
    step(1);
    chk("t1_idle_cycle", cyc, t + 116);
    chk("t1_busy_done", longint'(busy_o), 0);
    chk("t1_fired", longint'(fired_cnt_o), 1);
    step(3);

    // Two spaced requests, no guard: both fire.
    cfg(100, 10, 0);
    request();
    step(19);
    request();
    wait_idle(400);
    chk("t2_fired", longint'(fired_cnt_o), 3);
    chk("t2_late", longint'(late_cnt_o), 0);

    // Second target falls inside the first pulse window: discarded late.
    cfg(100, 50, 20);
    request();
    step(29);
    request();
    wait_idle(400);
    chk("t3_fired", longint'(fired_cnt_o), 4);
    chk("t3_late", longint'(late_cnt_o), 1);

    // Burst into a busy scheduler: eight queued, two dropped.
    cfg(1000, 1, 0);
    request();
    step(2);
    peak = 0;
    req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (int'(q_count_o) > peak) peak = int'(q_count_o);
    end
    req = 1'b0;
    chk("t4_peak", peak, 8);
    chk("t4_drop", longint'(drop_cnt_o), 2);
    wait_idle(3000);

    // Timestamp wrap: target crosses 2^32.
    force dut.ts_q = 32'hFFFF_FFCE;
    #1;
    release dut.ts_q;
    step(1);
    cfg(100, 10, 5);
    t = cyc;
    request();
    step(99);
    chk("t5_pre_pulse", longint'(sort_trig_o), 0);
    step(1);
    chk("t5_pulse", longint'(sort_trig_o), 1);
    wait_idle(400);

    // Flush mid-pulse with three entries queued and a coincident request.
    cfg(200, 30, 5);
    request();
    request();
    request();
    request();
    wait_trig(400);
    step(5);
    chk("t6_queued", longint'(q_count_o), 3);
    f0 = m_fired; l0 = m_late; d0 = m_drop;
    flush = 1'b1;
    req   = 1'b1;
    step(1);
    flush = 1'b0;
    req   = 1'b0;
    chk("t6_flush_trig", longint'(sort_trig_o), 0);
    chk("t6_flush_q", longint'(q_count_o), 0);
    step(400);
    chk("t6_fired_same", longint'(fired_cnt_o), f0);
    chk("t6_late_same", longint'(late_cnt_o), l0);
    chk("t6_drop_same", longint'(drop_cnt_o), d0);
    chk("t6_idle", longint'(busy_o), 0);

    // Reset mid-pulse with an entry queued.
    cfg(50, 20, 5);
    request();
    request();
    wait_trig(200);
    step(3);
    rst = 1'b1;
    step(1);
    chk("t7_trig", longint'(sort_trig_o), 0);
    chk("t7_busy", longint'(busy_o), 0);
    chk("t7_qcount", longint'(q_count_o), 0);
    chk("t7_fired", longint'(fired_cnt_o), 0);
    chk("t7_drop", longint'(drop_cnt_o), 0);
    chk("t7_late", longint'(late_cnt_o), 0);
    rst = 1'b0;
    step(3);

    // Randomized traffic with changing configuration, enable and flushes.
    for (int i = 0; i < 4000; i++) begin
      req   = ($urandom_range(0, 5) == 0);
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 399) == 0);
      delay = TW'($urandom_range(0, 150));
      dur   = TW'($urandom_range(0, 12));
      guard = TW'($urandom_range(0, 8));
      step(1);
    end
    req   = 1'b0;
    flush = 1'b0;
    en    = 1'b1;
    wait_idle(3000);
    chk("pending_pulses", longint'(exp_start.size() - mon_rd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
